// File: rtl/shift_ser_pkg.sv
// Shared types and defaults for the serial-transmit controller.
// Holds the FSM state encoding and the counter-width helper.
package shift_ser_pkg;

    localparam int unsigned DEF_WIDTH      = 32'd16;
    localparam int unsigned DEF_GAP_CYCLES = 32'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_ser_ctrl_if.sv
// Producer-side word handshake plus serial-line outputs of shift_ser_ctrl.
interface shift_ser_ctrl_if
    import shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             abort;
    logic             serOut;
    logic             serValid;
    logic             frameStart;
    logic             frameEnd;
    logic             busy;

    modport master (
        output inValid, inData, abort,
        input  inReady, serOut, serValid, frameStart, frameEnd, busy
    );

    modport slave (
        input  inValid, inData, abort,
        output inReady, serOut, serValid, frameStart, frameEnd, busy
    );
endinterface

// File: rtl/shift_reg_w.sv
// WIDTH-bit load/shift register: load beats shift, shift is left by one with zero fill.
module shift_reg_w #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next register value: load, shift or hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end else if (shift_en) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end else begin
            data_d = data_q;
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[WIDTH-1];
endmodule

// File: rtl/shift_ser_ctrl.sv
// Serial-transmit controller: accepts a word, shifts it out MSB first with frame markers.
// Define PARITY_EN to append an even-parity bit after the data bits.
module shift_ser_ctrl
    import shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    shift_ser_ctrl_if.slave   bus
);
    localparam int unsigned        CNT_W    = cnt_w(WIDTH);
    localparam int unsigned        GAP_W    = cnt_w(GAP_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 32'd1);
    localparam logic [GAP_W-1:0]   LAST_GAP = GAP_W'((GAP_CYCLES == 32'd0) ? 32'd0 : GAP_CYCLES - 32'd1);
    localparam state_e             POST_FRAME = (GAP_CYCLES == 32'd0) ? IDLE : GAP;
`ifdef PARITY_EN
    localparam state_e             POST_DATA  = PARITY;
`else
    localparam state_e             POST_DATA  = POST_FRAME;
`endif

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [GAP_W-1:0]   gap_d, gap_q;
    logic               load_s;
    logic               shift_s;
    logic [WIDTH-1:0]   load_data_s;
    logic               msb_s;
`ifdef PARITY_EN
    logic               par_d, par_q;
`endif

    shift_reg_w #(.WIDTH(WIDTH)) u_sreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .shift_en (shift_s),
        .d        (load_data_s),
        .msb      (msb_s)
    );

    // Next-state, counter and register-control logic; abort clears everything back to IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        load_data_s = {WIDTH{1'b0}};
`ifdef PARITY_EN
        par_d       = par_q;
`endif
        if (bus.abort) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                gap_d   = {GAP_W{1'b0}};
                load_s  = 1'b1;
`ifdef PARITY_EN
                par_d   = 1'b0;
`endif
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.inValid) begin
                        state_d     = SHIFT;
                        cnt_d       = {CNT_W{1'b0}};
                        load_s      = 1'b1;
                        load_data_s = bus.inData;
`ifdef PARITY_EN
                        par_d       = ^bus.inData;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    shift_s = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = POST_DATA;
                        cnt_d   = {CNT_W{1'b0}};
                        gap_d   = {GAP_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                PARITY: begin
                    state_d = POST_FRAME;
                    gap_d   = {GAP_W{1'b0}};
                end
                GAP: begin
                    if (gap_q == LAST_GAP) begin
                        state_d = IDLE;
                        gap_d   = {GAP_W{1'b0}};
                    end else begin
                        gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and parity bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serial outputs decoded purely from registered state.
    always_comb begin
        bus.serOut     = 1'b0;
        bus.serValid   = 1'b0;
        bus.frameStart = 1'b0;
        bus.frameEnd   = 1'b0;
        case (state_q)
            SHIFT: begin
                bus.serOut     = msb_s;
                bus.serValid   = 1'b1;
                bus.frameStart = (cnt_q == {CNT_W{1'b0}});
`ifdef PARITY_EN
                bus.frameEnd   = 1'b0;
`else
                bus.frameEnd   = (cnt_q == LAST_BIT);
`endif
            end
`ifdef PARITY_EN
            PARITY: begin
                bus.serOut     = par_q;
                bus.serValid   = 1'b1;
                bus.frameEnd   = 1'b1;
            end
`endif
            default: begin
                bus.serOut     = 1'b0;
                bus.serValid   = 1'b0;
            end
        endcase
    end

    // inReady also drops while reset is held, before any edge.
    assign bus.inReady = (state_q == IDLE) && rst;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Randomized self-checking bench for shift_ser_ctrl against a per-cycle expectation queue.
module tb_shift_ser_ctrl;
    import shift_ser_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned G = 1;
`ifdef PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned PERIOD = 1 + W + P + G;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_ser_ctrl_if #(.WIDTH(W)) bus ();
    shift_ser_ctrl #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic vld;
        logic bit_v;
        logic st;
        logic en;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int last_acc = -1;
    int acc_gap = -1;
    int n_acc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Frame as a list of line cycles: data bits MSB first, optional parity, then idle gap cycles.
    function automatic void model_accept(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.vld   = 1'b1;
            e.bit_v = w[W-1-i];
            e.st    = (i == 0);
            e.en    = (P == 0) && (i == W - 1);
            exp_q.push_back(e);
        end
        if (P != 0) begin
            e.vld   = 1'b1;
            e.bit_v = ($countones(w) % 2) == 1;
            e.st    = 1'b0;
            e.en    = 1'b1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < G; i++) begin
            e = '{1'b0, 1'b0, 1'b0, 1'b0};
            exp_q.push_back(e);
        end
        if (last_acc >= 0) acc_gap = cyc - last_acc;
        last_acc = cyc;
        n_acc++;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d, input logic ab);
        exp_t e;
        @(negedge clk);
        bus.inValid = v;
        bus.inData  = d;
        bus.abort   = ab;
        #1;
        if (exp_q.size() > 0) e = exp_q[0];
        else e = '{1'b0, 1'b0, 1'b0, 1'b0};
        check_val("serValid",   {31'd0, bus.serValid},   {31'd0, e.vld});
        check_val("serOut",     {31'd0, bus.serOut},     {31'd0, e.bit_v});
        check_val("frameStart", {31'd0, bus.frameStart}, {31'd0, e.st});
        check_val("frameEnd",   {31'd0, bus.frameEnd},   {31'd0, e.en});
        check_val("busy",       {31'd0, bus.busy},       {31'd0, (exp_q.size() > 0)});
        check_val("inReady",    {31'd0, bus.inReady},    {31'd0, (exp_q.size() == 0)});
        if (exp_q.size() > 0) begin
            if (ab) exp_q.delete();
            else void'(exp_q.pop_front());
        end else if (v && !ab) begin
            model_accept(d);
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
    endtask

    initial begin
        int acc0;
        bus.inValid = 1'b1;
        bus.inData  = 16'h1234;
        bus.abort   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_val("rst_serValid", {31'd0, bus.serValid}, 32'd0);
            check_val("rst_serOut",   {31'd0, bus.serOut},   32'd0);
            check_val("rst_busy",     {31'd0, bus.busy},     32'd0);
            check_val("rst_inReady",  {31'd0, bus.inReady},  32'd0);
            if (i == 1) bus.inValid = 1'b0;
        end
        #2;
        rst = 1'b1;
        drain(2);

        step(1'b1, 16'hA5C3, 1'b0);
        drain(PERIOD + 2);

        step(1'b1, 16'h0001, 1'b0);
        drain(PERIOD + 1);
        step(1'b1, 16'h0003, 1'b0);
        drain(PERIOD + 1);

        acc0 = n_acc;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step(1'b1, (n_acc == acc0) ? 16'hFFFF : 16'h0000, 1'b0);
        end
        check_val("b2b_accepts", n_acc - acc0, 32'd2);
        check_val("b2b_spacing", acc_gap, PERIOD);
        drain(PERIOD);

        step(1'b1, 16'hFFFF, 1'b0);
        drain(5);
        step(1'b1, 16'h1234, 1'b1);
        step(1'b1, 16'h1234, 1'b0);
        drain(PERIOD + 1);

        step(1'b1, 16'h5A3C, 1'b0);
        drain(8);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_serValid", {31'd0, bus.serValid}, 32'd0);
        check_val("arst_serOut",   {31'd0, bus.serOut},   32'd0);
        check_val("arst_busy",     {31'd0, bus.busy},     32'd0);
        check_val("arst_inReady",  {31'd0, bus.inReady},  32'd0);
        check_val("arst_reg",      {16'd0, dut.u_sreg.data_q}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drain(3);
        step(1'b1, 16'hC0DE, 1'b0);
        drain(PERIOD + 1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 19) == 0));
        end
        drain(PERIOD + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
